flash_boot_loader: RTL

//  Boot-time copier placed in front of the flash controller: drives its MMU-side request port,

---
 rtl/flash_boot_loader_pkg.sv | 22 ++
 rtl/flash_boot_loader_wait_timer.sv | 29 ++
 rtl/flash_boot_loader.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/flash_boot_loader_pkg.sv
// Shared widths, constants and FSM encoding for the flash-to-SRAM boot copier.
package flash_boot_loader_pkg;

    localparam int FADDR_W = 23;
    localparam int RADDR_W = 20;
    localparam int DATA_W  = 32;
    localparam int IDX_W   = 16;
    localparam int TMR_W   = 12;

    localparam logic [3:0] SEL_ALL = 4'b1111;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FREAD  = 3'd1,
        ST_FGAP   = 3'd2,
        ST_RWRITE = 3'd3,
        ST_RGAP   = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } state_e;

endpackage

// File: rtl/flash_boot_loader_wait_timer.sv
// Wait-cycle counter: cleared when a request is issued, counts while the
// target has not answered, flags when the count reaches TIMEOUT.
module boot_wait_timer
    import flash_boot_loader_pkg::*;
#(
    parameter logic [TMR_W-1:0] TIMEOUT = 12'd4095
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic timeout_o
);

    logic [TMR_W-1:0] count_q;

    // Counter; saturates at TIMEOUT so it can never wrap past the compare value.
    always_ff @(posedge clk) begin
        if (!rst)
            count_q <= '0;
        else if (clr_i)
            count_q <= '0;
        else if (en_i && (count_q != TIMEOUT))
            count_q <= count_q + 1'b1;
    end

    assign timeout_o = (count_q == TIMEOUT);

endmodule

// File: rtl/flash_boot_loader.sv
// Boot copier: reads WORD_COUNT words from flash and writes them to SRAM,
// holding the CPU stalled until the image is in place.
module flash_boot_loader
    import flash_boot_loader_pkg::*;
#(
    parameter logic [FADDR_W-1:0] SRC_BASE   = 23'h000000,
    parameter logic [RADDR_W-1:0] DST_BASE   = 20'h00000,
    parameter logic [IDX_W-1:0]   WORD_COUNT = 16'd1024,
    parameter logic [TMR_W-1:0]   TIMEOUT    = 12'd4095,
    parameter logic               AUTO_START = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    output logic               flash_ce_o,
    output logic               flash_we_o,
    output logic [FADDR_W-1:0] flash_addr_o,
    output logic [3:0]         flash_sel_o,
    input  logic [DATA_W-1:0]  flash_data_i,
    input  logic               flash_ready_i,
    output logic               ram_ce_o,
    output logic               ram_we_o,
    output logic [RADDR_W-1:0] ram_addr_o,
    output logic [3:0]         ram_sel_o,
    output logic [DATA_W-1:0]  ram_data_o,
    input  logic               ram_ready_i,
    output logic               stall_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               error_o
);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               flash_ce_q, flash_ce_d;
    logic [FADDR_W-1:0] flash_addr_q, flash_addr_d;
    logic               ram_ce_q, ram_ce_d;
    logic               ram_we_q, ram_we_d;
    logic [RADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [3:0]         ram_sel_q, ram_sel_d;
    logic [DATA_W-1:0]  ram_data_q, ram_data_d;
    logic               stall_q, stall_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
    logic               tmr_clr, tmr_en, tmr_timeout;

    // Timer restarts on entry to a waiting state and runs while the target is silent.
    assign tmr_clr = ((state_d == ST_FREAD)  && (state_q != ST_FREAD)) ||
                     ((state_d == ST_RWRITE) && (state_q != ST_RWRITE));
    assign tmr_en  = ((state_q == ST_FREAD)  && !flash_ready_i) ||
                     ((state_q == ST_RWRITE) && !ram_ready_i);

    boot_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (tmr_clr),
        .en_i      (tmr_en),
        .timeout_o (tmr_timeout)
    );

    // State, index and output registers; outputs are computed from the next state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            flash_ce_q   <= 1'b0;
            flash_addr_q <= '0;
            ram_ce_q     <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_sel_q    <= '0;
            ram_data_q   <= '0;
            stall_q      <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            flash_ce_q   <= flash_ce_d;
            flash_addr_q <= flash_addr_d;
            ram_ce_q     <= ram_ce_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_sel_q    <= ram_sel_d;
            ram_data_q   <= ram_data_d;
            stall_q      <= stall_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    // Next-state and word index; a ready on the timeout cycle still advances.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (AUTO_START || start_i) begin
                    idx_d   = '0;
                    state_d = (WORD_COUNT == '0) ? ST_DONE : ST_FREAD;
                end
            end
            ST_FREAD: begin
                if (flash_ready_i)    state_d = ST_FGAP;
                else if (tmr_timeout) state_d = ST_ERR;
            end
            ST_FGAP:   state_d = ST_RWRITE;
            ST_RWRITE: begin
                if (ram_ready_i)      state_d = ST_RGAP;
                else if (tmr_timeout) state_d = ST_ERR;
            end
            ST_RGAP: begin
                if (idx_q == IDX_W'(WORD_COUNT - 1'b1)) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = ST_FREAD;
                end
            end
            ST_DONE: state_d = ST_DONE;
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output next values; addresses and write data hold between requests.
    always_comb begin
        flash_ce_d   = 1'b0;
        flash_addr_d = flash_addr_q;
        ram_ce_d     = 1'b0;
        ram_we_d     = 1'b0;
        ram_addr_d   = ram_addr_q;
        ram_sel_d    = '0;
        ram_data_d   = ram_data_q;
        stall_d      = 1'b1;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        error_d      = 1'b0;
        if ((state_q == ST_FREAD) && flash_ready_i)
            ram_data_d = flash_data_i;
        case (state_d)
            ST_FREAD: begin
                flash_ce_d   = 1'b1;
                flash_addr_d = SRC_BASE + FADDR_W'({idx_d, 2'b00});
                busy_d       = 1'b1;
            end
            ST_FGAP, ST_RGAP: busy_d = 1'b1;
            ST_RWRITE: begin
                ram_ce_d   = 1'b1;
                ram_we_d   = 1'b1;
                ram_sel_d  = SEL_ALL;
                ram_addr_d = DST_BASE + RADDR_W'(idx_d);
                busy_d     = 1'b1;
            end
            ST_DONE: begin
                done_d  = 1'b1;
                stall_d = 1'b0;
            end
            ST_ERR:  error_d = 1'b1;
            default: ;
        endcase
    end

    assign flash_ce_o   = flash_ce_q;
    assign flash_we_o   = 1'b0;
    assign flash_addr_o = flash_addr_q;
    assign flash_sel_o  = SEL_ALL;
    assign ram_ce_o     = ram_ce_q;
    assign ram_we_o     = ram_we_q;
    assign ram_addr_o   = ram_addr_q;
    assign ram_sel_o    = ram_sel_q;
    assign ram_data_o   = ram_data_q;
    assign stall_o      = stall_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign error_o      = error_q;

endmodule
